// File: rtl/processor_pkg.sv
// Shared processor definitions: instruction field layout, jump opcodes and defaults.
package processor_pkg;

  localparam int unsigned PC_W_DEF    = 8;
  localparam int unsigned INSTR_W_DEF = 16;

  // Instruction field bit positions
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned ADDR_MSB = 8;
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned OPC_W    = OPC_MSB - OPC_LSB + 1;
  localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

  // Opcodes OP_JMP_LO..OP_JMP_HI are jumps that redirect fetch
  localparam logic [OPC_W-1:0] OP_JMP_LO = 4'd12;
  localparam logic [OPC_W-1:0] OP_JMP_HI = 4'd14;

  function automatic logic is_jump(input logic [OPC_W-1:0] opc);
    return (opc >= OP_JMP_LO) && (opc <= OP_JMP_HI);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; clear has priority over push/pop.
module fetch_queue #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, empty, do_push, do_pop;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop_i && !empty;
    // A push into a full queue is only safe when the head leaves in the same cycle
    do_push  = push_i && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - (AW+1)'(1);
      end
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head outputs come straight from registered state; zero while empty
  always_comb begin
    valid_o = !empty;
    data_o  = empty ? '0 : mem_q[rd_ptr_q];
    count_o = count_q;
  end

  // Upstream reserves space before issuing, so overflow means an issue-logic bug
  push_has_space_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !clear_i && full && !pop_i));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the pc, issues ROM reads, predecodes jumps and
// buffers fetched {pc, instr} pairs for decode.
module instr_fetch
  import processor_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned PROG_LEN = 16,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_en,
  output logic [PC_W-1:0]           imem_addr,
  input  logic [INSTR_W-1:0]        imem_rdata,
  input  logic                      flush,
  input  logic [PC_W-1:0]           flush_pc,
  output logic                      if_valid,
  input  logic                      if_ready,
  output logic [INSTR_W-1:0]        if_instr,
  output logic [PC_W-1:0]           if_pc,
  output logic [$clog2(QDEPTH):0]   if_count
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam int unsigned QW = PC_W + INSTR_W;

  // Out-of-range pcs restart at slot 0
  function automatic logic [PC_W-1:0] sanitize_pc(input logic [PC_W-1:0] p);
    return (32'(p) >= PROG_LEN) ? '0 : p;
  endfunction

  function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] p);
    return (32'(p) == PROG_LEN - 1) ? '0 : p + PC_W'(1);
  endfunction

  // Relative jump, wrapping modulo 2^PC_W before the range check
  function automatic logic [PC_W-1:0] jump_tgt(input logic [PC_W-1:0]   p,
                                               input logic [ADDR_W-1:0] a);
    logic [PC_W-1:0] sum;
    sum = p + PC_W'(a);
    return sanitize_pc(sum);
  endfunction

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            squash_q, squash_d;

  logic            pop, issue, push, resp_jump;
  logic [OW-1:0]   occ;
  logic [QW-1:0]   q_head;
  logic [CW-1:0]   q_count;
  logic            q_valid;

  // Handshake, issue and response decode
  always_comb begin
    pop       = q_valid && if_ready;
    // Space is reserved for the in-flight fetch; a pop this cycle frees a slot
    occ       = OW'(q_count) + OW'(inflight_q);
    issue     = !reset && !flush && ((occ - OW'(pop)) < OW'(QDEPTH));
    push      = inflight_q && !squash_q && !flush;
    resp_jump = push && is_jump(imem_rdata[OPC_MSB:OPC_LSB]);
  end

  // Next pc and in-flight tracking; flush beats jump redirect beats sequential
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
    // The fetch issued alongside a jump response is on the wrong path
    squash_d      = issue && resp_jump;
    if (flush) begin
      fetch_pc_d = sanitize_pc(flush_pc);
    end else if (resp_jump) begin
      fetch_pc_d = jump_tgt(inflight_pc_q, imem_rdata[ADDR_MSB:ADDR_LSB]);
    end else if (issue) begin
      fetch_pc_d = seq_pc(fetch_pc_q);
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      squash_q      <= squash_d;
    end
  end

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  ({inflight_pc_q, imem_rdata}),
    .pop_i   (pop),
    .clear_i (flush),
    .valid_o (q_valid),
    .data_o  (q_head),
    .count_o (q_count)
  );

  // Output drive: ROM request and queue head
  always_comb begin
    imem_en   = issue;
    imem_addr = fetch_pc_q;
    if_valid  = q_valid;
    if_pc     = q_head[QW-1:INSTR_W];
    if_instr  = q_head[INSTR_W-1:0];
    if_count  = q_count;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle synchronous ROM model.
module tb_instr_fetch;

  localparam int PC_W = 8;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               flush = 1'b0;
  logic [PC_W-1:0]    flush_pc = '0;
  logic               if_valid;
  logic               if_ready = 1'b0;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic [2:0]         if_count;

  instr_fetch #(
    .PC_W     (8),
    .INSTR_W  (16),
    .PROG_LEN (16),
    .QDEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_count   (if_count)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom[imem_addr];
  end

  // Delivery / issue monitor on the falling edge
  int cyc = 0;
  bit mon_en = 1'b0;
  int dpc[$];
  int dins[$];
  int dcyc[$];
  int iss[$];

  always @(negedge clk) begin
    if (mon_en && if_valid && if_ready) begin
      dpc.push_back(int'(if_pc));
      dins.push_back(int'(if_instr));
      dcyc.push_back(cyc);
    end
    if (mon_en && imem_en) iss.push_back(int'(imem_addr));
    cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int c0 = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_mon();
    dpc.delete();
    dins.delete();
    dcyc.delete();
    iss.delete();
  endtask

  // Apply a reset, release it and note the monitor cycle at release
  task automatic do_reset(input bit ready);
    mon_en = 1'b0;
    reset = 1'b1;
    flush = 1'b0;
    if_ready = ready;
    tick(2);
    reset = 1'b0;
    c0 = cyc;
    clear_mon();
    mon_en = 1'b1;
  endtask

  task automatic check_seq(input string tag, input int exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < dpc.size()) begin
        check($sformatf("%s_pc[%0d]", tag, i), dpc[i], exp[i]);
        check($sformatf("%s_instr[%0d]", tag, i), dins[i], int'(rom[exp[i]]));
      end else begin
        check($sformatf("%s_missing[%0d]", tag, i), -1, exp[i]);
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_imem_en"}, int'(imem_en), 0);
    check({tag, "_imem_addr"}, int'(imem_addr), 0);
    check({tag, "_if_valid"}, int'(if_valid), 0);
    check({tag, "_if_instr"}, int'(if_instr), 0);
    check({tag, "_if_pc"}, int'(if_pc), 0);
    check({tag, "_if_count"}, int'(if_count), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp[$];
    int first_bubble_free;
    bit found4;

    for (int i = 0; i < 256; i++) rom[i] = {4'h1, 12'(i)};
    // Opcodes 11 and 15 sit just outside the jump range
    rom[5] = {4'hF, 3'b0, 9'd2};
    rom[6] = {4'hB, 3'b0, 9'd3};

    // Reset state
    tick(2);
    #1;
    check_zero_outputs("rst");

    // Straight-line program, decode always ready
    do_reset(1'b1);
    #1;
    check("p1_first_issue_en", int'(imem_en), 1);
    check("p1_first_issue_addr", int'(imem_addr), 0);
    tick(20);
    exp.delete();
    for (int i = 0; i < 18; i++) exp.push_back(i % 16);
    check_seq("p1", exp);
    if (dcyc.size() >= 18) begin
      check("p1_latency", dcyc[0] - c0, 2);
      first_bubble_free = dcyc[17] - dcyc[0];
      check("p1_no_gaps", first_bubble_free, 17);
    end else begin
      check("p1_count", dcyc.size(), 18);
    end

    // Jump at pc 3 by +5
    rom[3] = {4'hC, 3'b0, 9'd5};
    do_reset(1'b1);
    tick(9);
    exp = '{0, 1, 2, 3, 8, 9};
    check_seq("p2", exp);
    if (dcyc.size() >= 6) begin
      check("p2_cyc3", dcyc[3] - dcyc[0], 3);
      check("p2_cyc8_bubble", dcyc[4] - dcyc[0], 5);
      check("p2_cyc9", dcyc[5] - dcyc[0], 6);
    end else begin
      check("p2_count", dcyc.size(), 6);
    end
    found4 = 1'b0;
    foreach (iss[i]) if (iss[i] == 4) found4 = 1'b1;
    check("p2_pc4_issued", int'(found4), 1);

    // Jump at pc 10 by +9 lands out of range and restarts at 0
    rom[3] = {4'h1, 12'd3};
    rom[10] = {4'hE, 3'b0, 9'd9};
    do_reset(1'b1);
    tick(18);
    exp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 1};
    check_seq("p3", exp);
    rom[10] = {4'h1, 12'd10};

    // Backpressure from the start
    do_reset(1'b0);
    tick(8);
    check("p4_count_full", int'(if_count), 4);
    check("p4_imem_en_off", int'(imem_en), 0);
    check("p4_valid", int'(if_valid), 1);
    check("p4_head_pc", int'(if_pc), 0);
    tick(2);
    check("p4_head_hold_pc", int'(if_pc), 0);
    check("p4_head_hold_instr", int'(if_instr), int'(rom[0]));
    clear_mon();
    if_ready = 1'b1;
    tick(12);
    exp = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_seq("p4", exp);
    check("p4_resume_addr", (iss.size() > 0) ? iss[0] : -1, 4);

    // Flush with three queued entries and one fetch in flight
    do_reset(1'b0);
    tick(4);
    check("p5_pre_count", int'(if_count), 3);
    flush = 1'b1;
    flush_pc = 8'd7;
    #1;
    check("p5_no_issue_on_flush", int'(imem_en), 0);
    tick(1);
    flush = 1'b0;
    #1;
    check("p5_valid_after", int'(if_valid), 0);
    check("p5_count_after", int'(if_count), 0);
    mon_en = 1'b0;
    clear_mon();
    mon_en = 1'b1;
    if_ready = 1'b1;
    tick(8);
    exp = '{7, 8, 9, 10};
    check_seq("p5", exp);

    // Out-of-range flush target restarts at 0
    mon_en = 1'b0;
    flush = 1'b1;
    flush_pc = 8'd20;
    tick(1);
    flush = 1'b0;
    #1;
    check("p5b_valid_after", int'(if_valid), 0);
    clear_mon();
    mon_en = 1'b1;
    tick(6);
    exp = '{0, 1, 2};
    check_seq("p5b", exp);

    // Short reset pulse mid-stream with a fetch in flight
    mon_en = 1'b0;
    tick(3);
    reset = 1'b1;
    #1;
    check("p6_valid", int'(if_valid), 0);
    check("p6_count", int'(if_count), 0);
    check("p6_imem_en", int'(imem_en), 0);
    check("p6_if_pc", int'(if_pc), 0);
    check("p6_if_instr", int'(if_instr), 0);
    #1;
    reset = 1'b0;
    c0 = cyc;
    clear_mon();
    mon_en = 1'b1;
    tick(6);
    exp = '{0, 1, 2};
    check_seq("p6", exp);
    check("p6_latency", (dcyc.size() > 0) ? dcyc[0] - c0 : -1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
